// File: rtl/uart_cmd_pkg.sv
// Shared command/response byte codes and scheduler state encoding for the
// UART command scheduler slice.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_CLEAR = 8'h63;  // 'c'
  localparam logic [7:0] CMD_DHT   = 8'h68;  // 'h'
  localparam logic [7:0] CMD_SR    = 8'h75;  // 'u'

  localparam logic [7:0] RSP_OK  = 8'h4B;    // 'K'
  localparam logic [7:0] RSP_TMO = 8'h54;    // 'T'
  localparam logic [7:0] RSP_ERR = 8'h3F;    // '?'

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_sched_if.sv
// RX/TX FIFO handshake bundle between the command scheduler (master) and the
// UART FIFOs (slave).
interface uart_cmd_sched_if;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;

  modport master (
    input  rx_empty, rx_data, tx_full,
    output rx_pop, tx_push, tx_data
  );

  modport slave (
    output rx_empty, rx_data, tx_full,
    input  rx_pop, tx_push, tx_data
  );
endinterface

// File: rtl/cmd_timeout_timer.sv
// Saturating sensor-wait timer: cleared on clr, counts while en, flags
// expired once it has reached TIMEOUT_CYC-1 and then holds there.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == LAST);

  // Stops at LAST so a stalled WAIT can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_sched.sv
// UART command scheduler: pops one command byte, drives stopwatch/sensor
// controls, and pushes exactly one response byte per command.
module uart_cmd_sched
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_sched_if.master bus,
  output logic             o_run_stop,
  output logic             o_clear,
  output logic             dht_start,
  input  logic             dht_done,
  output logic             sr_start,
  input  logic             sr_done,
  output logic             o_busy
);

  state_t     state, state_nxt;
  logic [7:0] cmd, resp, resp_nxt;
  logic       cmd_ld, resp_ld, run_ld, run_nxt, clr_nxt;
  logic       tmr_clr, tmr_en, tmo, sensor_done;

  cmd_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmo)
  );

  // Only the sensor that was started may end the wait.
  assign sensor_done = (cmd == CMD_DHT) ? dht_done : sr_done;
  assign o_busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cmd_ld       = 1'b0;
    resp_ld      = 1'b0;
    resp_nxt     = resp;
    run_ld       = 1'b0;
    run_nxt      = 1'b0;
    clr_nxt      = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    bus.rx_pop   = 1'b0;
    bus.tx_push  = 1'b0;
    bus.tx_data  = 8'h00;
    dht_start    = 1'b0;
    sr_start     = 1'b0;
    // Strobes are held off while reset is asserted so no byte is consumed,
    // pushed or re-triggered during the reset cycle.
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (!bus.rx_empty) begin
            bus.rx_pop = 1'b1;
            cmd_ld     = 1'b1;
            state_nxt  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          resp_ld   = 1'b1;
          state_nxt = ST_RESP;
          case (cmd)
            CMD_RUN:   begin run_ld = 1'b1; run_nxt = 1'b1; resp_nxt = RSP_OK; end
            CMD_STOP:  begin run_ld = 1'b1; run_nxt = 1'b0; resp_nxt = RSP_OK; end
            CMD_CLEAR: begin clr_nxt = 1'b1; resp_nxt = RSP_OK; end
            CMD_DHT, CMD_SR: begin
              resp_ld   = 1'b0;
              state_nxt = ST_START;
            end
            default:   resp_nxt = RSP_ERR;
          endcase
        end
        ST_START: begin
          dht_start = (cmd == CMD_DHT);
          sr_start  = (cmd == CMD_SR);
          tmr_clr   = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          tmr_en = 1'b1;
          // A done landing on the expiry cycle still counts as success.
          if (sensor_done) begin
            resp_ld   = 1'b1;
            resp_nxt  = RSP_OK;
            state_nxt = ST_RESP;
          end else if (tmo) begin
            resp_ld   = 1'b1;
            resp_nxt  = RSP_TMO;
            state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          if (!bus.tx_full) begin
            bus.tx_push = 1'b1;
            bus.tx_data = resp;
            state_nxt   = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd        <= 8'h00;
      resp       <= 8'h00;
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
    end else begin
      if (cmd_ld)  cmd        <= bus.rx_data;
      if (resp_ld) resp       <= resp_nxt;
      if (run_ld)  o_run_stop <= run_nxt;
      o_clear <= clr_nxt;
    end
  end

endmodule
